// File: rtl/fp_mul_pipe_if.sv
// rtl/fp_mul_pipe_if.sv - operand/result handshake bundle for fp_mul_pipe
interface fp_mul_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    logic                   in_valid;
    logic                   in_ready;
    logic [EXP_W+MAN_W:0]   in_a;
    logic [EXP_W+MAN_W:0]   in_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [EXP_W+MAN_W:0]   out_result;
    logic [2:0]             out_flags;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 3-stage IEEE-754 multiplier, FTZ, saturating; FPMUL_RNE_EN selects round-to-nearest-even
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic          clk,
    input  logic          rst,
    fp_mul_pipe_if.slave  bus
);
    localparam int W  = EXP_W + MAN_W + 1;
    localparam int SW = MAN_W + 1;
    localparam int PW = 2 * SW;
    localparam int EW = EXP_W + 2;
    localparam int HW = MAN_W + 2;

    localparam logic [EW-1:0]        BIAS     = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic [W-1:0]         QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic stall;
    logic advance;

    assign stall        = bus.out_valid && !bus.out_ready;
    assign advance      = !stall;
    assign bus.in_ready = !rst && !stall;

    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic             a_zero, a_inf, a_nan;
    logic             b_zero, b_inf, b_nan;

    assign a_exp  = bus.in_a[W-2:MAN_W];
    assign b_exp  = bus.in_b[W-2:MAN_W];
    assign a_frac = bus.in_a[MAN_W-1:0];
    assign b_frac = bus.in_b[MAN_W-1:0];

    // Subnormal inputs are classified as zero (flush-to-zero)
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (&a_exp) && (a_frac == '0);
    assign b_inf  = (&b_exp) && (b_frac == '0);
    assign a_nan  = (&a_exp) && (a_frac != '0);
    assign b_nan  = (&b_exp) && (b_frac != '0);

    logic                 s1_valid, s1_sign, s1_nan, s1_inf, s1_zero;
    logic [SW-1:0]        s1_ma, s1_mb;
    logic signed [EW-1:0] s1_exp;

    logic                 s2_valid, s2_sign, s2_nan, s2_inf, s2_zero;
    logic [HW-1:0]        s2_hi;
    logic signed [EW-1:0] s2_exp;

`ifdef FPMUL_RNE_EN
    logic          s2_g, s2_st;
    logic [PW-1:0] prod;

    assign prod = {{SW{1'b0}}, s1_ma} * {{SW{1'b0}}, s1_mb};
`endif

    logic                 msb;
    logic                 carry;
    logic [MAN_W-1:0]     frac_t, frac_r;
    logic signed [EW-1:0] exp_n;
    logic                 overflow, underflow;
    logic [W-1:0]         res;
    logic [2:0]           flg;

    assign msb    = s2_hi[HW-1];
    assign frac_t = msb ? s2_hi[MAN_W:1] : s2_hi[MAN_W-1:0];

`ifdef FPMUL_RNE_EN
    logic guard, sticky, round_up;

    assign guard    = msb ? s2_hi[0] : s2_g;
    assign sticky   = msb ? (s2_g | s2_st) : s2_st;
    assign round_up = guard && (sticky || frac_t[0]);
    // A carry out leaves frac_r wrapped to zero, which is the renormalised fraction
    assign {carry, frac_r} = {1'b0, frac_t} + {{MAN_W{1'b0}}, round_up};
`else
    assign carry  = 1'b0;
    assign frac_r = frac_t;
`endif

    assign exp_n     = s2_exp + {{(EW-1){1'b0}}, msb} + {{(EW-1){1'b0}}, carry};
    assign overflow  = (exp_n >= EXP_MAX);
    assign underflow = (exp_n <= EXP_ZERO);

    always_comb begin
        res = {s2_sign, exp_n[EXP_W-1:0], frac_r};
        flg = 3'b000;
        if (s2_nan) begin
            res = QNAN;
            flg = 3'b100;
        end else if (s2_inf) begin
            res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s2_zero) begin
            res = {s2_sign, {(W-1){1'b0}}};
        end else if (overflow) begin
            res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg = 3'b010;
        end else if (underflow) begin
            res = {s2_sign, {(W-1){1'b0}}};
            flg = 3'b001;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid       <= 1'b0;
            s2_valid       <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.out_flags  <= '0;
        end else if (advance) begin
            s1_valid <= bus.in_valid;
            s1_sign  <= bus.in_a[W-1] ^ bus.in_b[W-1];
            s1_nan   <= a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
            s1_inf   <= a_inf || b_inf;
            s1_zero  <= a_zero || b_zero;
            s1_ma    <= {1'b1, a_frac};
            s1_mb    <= {1'b1, b_frac};
            s1_exp   <= $signed({2'b00, a_exp} + {2'b00, b_exp} - BIAS);

            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_nan   <= s1_nan;
            s2_inf   <= s1_inf;
            s2_zero  <= s1_zero;
            s2_exp   <= s1_exp;
`ifdef FPMUL_RNE_EN
            s2_hi    <= prod[PW-1:MAN_W];
            s2_g     <= prod[MAN_W-1];
            s2_st    <= |prod[MAN_W-2:0];
`else
            s2_hi    <= HW'(({{SW{1'b0}}, s1_ma} * {{SW{1'b0}}, s1_mb}) >> MAN_W);
`endif

            bus.out_valid  <= s2_valid;
            bus.out_result <= res;
            bus.out_flags  <= flg;
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - directed self-checking bench for fp_mul_pipe (single and double precision)
module tb_fp_mul_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fp_mul_pipe_if #(.EXP_W(8),  .MAN_W(23)) sp_if ();
    fp_mul_pipe_if #(.EXP_W(11), .MAN_W(52)) dp_if ();

    fp_mul_pipe #(.EXP_W(8),  .MAN_W(23)) u_sp (.clk(clk), .rst(rst), .bus(sp_if));
    fp_mul_pipe #(.EXP_W(11), .MAN_W(52)) u_dp (.clk(clk), .rst(rst), .bus(dp_if));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic run_sp(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic [2:0] f);
        int lat;
        @(negedge clk);
        sp_if.in_valid  = 1'b1;
        sp_if.in_a      = a;
        sp_if.in_b      = b;
        sp_if.out_ready = 1'b1;
        @(posedge clk);
        #1 sp_if.in_valid = 1'b0;
        lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            if (sp_if.out_valid) break;
            @(posedge clk);
            lat++;
        end
        check({tag, " lat"}, 64'(lat), 64'd3);
        check({tag, " res"}, 64'(sp_if.out_result), 64'(r));
        check({tag, " flg"}, 64'(sp_if.out_flags), 64'(f));
    endtask

    logic [31:0] bp_a   [6];
    logic [31:0] bp_exp [6];
    logic [31:0] rne_exp;

    initial begin
        int idx;
        int got;
        int lat;
        int seen;
        bit acc;

        sp_if.in_valid = 1'b0; sp_if.in_a = '0; sp_if.in_b = '0; sp_if.out_ready = 1'b1;
        dp_if.in_valid = 1'b0; dp_if.in_a = '0; dp_if.in_b = '0; dp_if.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst out_valid",  64'(sp_if.out_valid),  64'd0);
        check("rst out_result", 64'(sp_if.out_result), 64'd0);
        check("rst out_flags",  64'(sp_if.out_flags),  64'd0);
        check("rst in_ready",   64'(sp_if.in_ready),   64'd0);
        rst = 1'b0;
        #1 check("idle in_ready", 64'(sp_if.in_ready), 64'd1);

`ifdef FPMUL_RNE_EN
        rne_exp = 32'h40100002;
`else
        rne_exp = 32'h40100001;
`endif
        run_sp("2x3",      32'h40000000, 32'h40400000, 32'h40C00000, 3'b000);
        run_sp("1.5sq",    32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000);
        run_sp("round",    32'h3FC00001, 32'h3FC00001, rne_exp,      3'b000);
        run_sp("neg",      32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000);
        run_sp("inf0",     32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100);
        run_sp("nan",      32'h7F800001, 32'h3F800000, 32'h7FC00000, 3'b100);
        run_sp("ninf",     32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000);
        run_sp("infinf",   32'h7F800000, 32'h7F800000, 32'h7F800000, 3'b000);
        run_sp("nzero",    32'h80000000, 32'h40A00000, 32'h80000000, 3'b000);
        run_sp("ftz",      32'h00000001, 32'h40000000, 32'h00000000, 3'b000);
        run_sp("ovf",      32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 3'b010);
        run_sp("unf",      32'h00800000, 32'h00800000, 32'h00000000, 3'b001);

        // Backpressure: inputs from cycle 0, out_ready low in cycles 2..8
        bp_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
        bp_exp = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000, 32'h41400000};
        idx = 0;
        got = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            sp_if.out_ready = !(cyc >= 2 && cyc <= 8);
            sp_if.in_valid  = (idx < 6);
            sp_if.in_a      = bp_a[idx < 6 ? idx : 0];
            sp_if.in_b      = 32'h40000000;
            #1;
            check($sformatf("bp in_ready c%0d", cyc), 64'(sp_if.in_ready), 64'(cyc < 3 || cyc >= 9));
            check($sformatf("bp out_hs c%0d", cyc), 64'(sp_if.out_valid && sp_if.out_ready),
                  64'(cyc >= 9 && cyc <= 14));
            if (sp_if.out_valid && sp_if.out_ready) begin
                check($sformatf("bp res %0d", got), 64'(sp_if.out_result), 64'(bp_exp[got < 6 ? got : 5]));
                got++;
            end
            acc = sp_if.in_valid && sp_if.in_ready;
            @(posedge clk);
            if (acc) idx++;
        end
        #1 sp_if.in_valid = 1'b0;
        check("bp count", 64'(got), 64'd6);
        check("bp accepted", 64'(idx), 64'd6);

        // Reset with three results in flight
        sp_if.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sp_if.in_valid = 1'b1;
            sp_if.in_a     = bp_a[i];
            sp_if.in_b     = 32'h40000000;
            @(posedge clk);
        end
        #1 sp_if.in_valid = 1'b0;
        @(negedge clk);
        check("pre-rst out_valid", 64'(sp_if.out_valid), 64'd1);
        rst = 1'b1;
        #1 check("rst-hi in_ready", 64'(sp_if.in_ready), 64'd0);
        @(posedge clk);
        #1 check("post-rst out_valid", 64'(sp_if.out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sp_if.out_valid) seen++;
        end
        check("stale results", 64'(seen), 64'd0);

        // Double precision 2 x 3
        @(negedge clk);
        dp_if.in_valid = 1'b1;
        dp_if.in_a     = 64'h4000000000000000;
        dp_if.in_b     = 64'h4008000000000000;
        @(posedge clk);
        #1 dp_if.in_valid = 1'b0;
        lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            if (dp_if.out_valid) break;
            @(posedge clk);
            lat++;
        end
        check("dp lat", 64'(lat), 64'd3);
        check("dp res", dp_if.out_result, 64'h4018000000000000);
        check("dp flg", 64'(dp_if.out_flags), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
Parametrised, pipelined IEEE-754 binary floating-point multiplier. It succeeds the single-cycle combinational single-precision multiplier with configurable exponent and mantissa widths, a 3-stage pipeline with valid/ready flow control, special-value handling (zero, inf, NaN), overflow/underflow saturation and exception flags. It sits between operand-producing logic and any result consumer that may apply backpressure.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored fraction width (significand = MAN_W+1 bits with hidden 1)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset: one clock; reset is synchronous and active-high
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts operands this cycle
in_a  in  EXP_W+MAN_W+1  operand A {sign, exp, frac}
in_b  in  EXP_W+MAN_W+1  operand B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  EXP_W+MAN_W+1  product
out_flags  out  3  {invalid, overflow, underflow}, aligned with out_result

Behaviour:
- Reset (rst=1 at clock edge): all stage valid bits, out_valid, out_result, out_flags cleared to 0; in_ready=0 while rst is high.
- Transfers: input on in_valid&&in_ready; output on out_valid&&out_ready.
- Stall = out_valid && !out_ready. in_ready = !rst && !stall (combinational). On stall, every stage holds its contents; otherwise all stages advance each cycle (bubbles propagate as valid=0).
- Latency: exactly 3 cycles from accepted input to out_valid, with no stall. Throughput 1/cycle. Order preserved; no drop or duplication.
- S1 unpack/classify: sign = sA^sB; classify each operand as zero (exp==0, any frac: subnormals flushed to zero), inf (exp all-ones, frac==0), NaN (exp all-ones, frac!=0), normal. Register significands with hidden 1, exponent sum as signed EXP_W+2 bits: eA+eB-bias.
- S2: (MAN_W+1)x(MAN_W+1) unsigned multiply into a 2*MAN_W+2 bit product; class info piped alongside.
- S3 normalise/round/pack:
  - If product MSB set: shift right 1, exponent +1.
  - Rounding per Optional Feature; a rounding carry-out renormalises (exponent +1, frac=0).
  - Biased exp >= 2^EXP_W-1 -> signed inf, overflow=1.
  - Biased exp <= 0 -> signed zero, underflow=1 (no subnormal output).
- Special precedence, highest first:
  - Any NaN, or inf*zero -> canonical qNaN (sign 0, exp all-ones, frac MSB=1, rest 0), invalid=1.
  - Any inf -> signed inf, no flags.
  - Any zero -> signed zero, no flags.
- Simultaneous output handshake and new input while full: legal, both complete in the same cycle.
- rst mid-operation: in-flight results discarded; nothing emitted afterwards.

Optional Feature:
FPMUL_RNE_EN
- Defined: round-to-nearest-even using guard bit and sticky (OR of all lower bits); round up if guard && (sticky || lsb).
- Undefined: truncation (round toward zero), guard/sticky logic absent; matches prior-generation results.

Test Plan:
- Default params, in_a=0x40000000, in_b=0x40400000, out_ready=1 -> 3 cycles later out_result=0x40C00000, flags=000.
- 0x3FC00000*0x3FC00000 -> 0x40100000 (normalisation shift path); 0x3FC00001*0x3FC00001 -> 0x40100002 with FPMUL_RNE_EN, 0x40100001 without.
- 0x7F800000*0x00000000 -> 0x7FC00000, flags=100; 0xFF800000*0x40000000 -> 0xFF800000, flags=000; 0x00000001*0x40000000 -> 0x00000000 (FTZ).
- 0x7F7FFFFF*0x40000000 -> 0x7F800000, flags=010; 0x00800000*0x00800000 -> 0x00000000, flags=001.
- Backpressure: 6 back-to-back inputs, out_ready=0 for cycles 2-8 -> in_ready drops while out_valid&&!out_ready; all 6 results emerge in order, none lost or duplicated.
- Assert rst with 3 results in flight -> out_valid=0 next cycle, no stale result appears; EXP_W=11/MAN_W=52: 0x4000000000000000*0x4008000000000000 -> 0x4018000000000000.
